// File: rtl/local_bias_seq.sv
// rtl/local_bias_seq.sv - power-up sequencer and analog testbus controller for local_bias
module local_bias_seq #(
    parameter int  DEBOUNCE_CYCLES = 8,
    parameter int  SETTLE_CYCLES   = 64,
    parameter real VDDANA_1P8_REF  = 1.8,
    parameter real VDDANA_0P8_REF  = 0.8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  real        vddana_1p8,
    input  real        vddana_0p8,
    input  real        vssana,
    input  logic       atb_req,
    input  logic [1:0] atb_sel,
    output logic       pdb,
    output logic [1:0] atb_ena,
    output logic       bias_ready,
    output logic       fault,
    output logic [2:0] fault_src,
    output logic       atb_ack,
    output logic       atb_err
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_PWR   = 3'd2;
    localparam logic [2:0] S_READY = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] set_cnt;
    logic          ok_1p8;
    logic          ok_0p8;
    logic          ok_vss;
    logic          supply_ok;
    logic          accept;

    // Inclusive window checks on the analog rails
    always_comb begin
        ok_1p8    = (vddana_1p8 >= 0.95 * VDDANA_1P8_REF) && (vddana_1p8 <= 1.05 * VDDANA_1P8_REF);
        ok_0p8    = (vddana_0p8 >= 0.95 * VDDANA_0P8_REF) && (vddana_0p8 <= 1.05 * VDDANA_0P8_REF);
        ok_vss    = (vssana >= -0.05) && (vssana <= 0.05);
        supply_ok = ok_1p8 && ok_0p8 && ok_vss;
        accept    = atb_req && !atb_ack;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF:   state_nxt = S_WAIT;
                S_WAIT:  if (supply_ok && deb_cnt == DEB_LAST) state_nxt = S_PWR;
                S_PWR: begin
                    if (!supply_ok)                state_nxt = S_FAULT;
                    else if (set_cnt == SET_LAST)  state_nxt = S_READY;
                end
                S_READY: if (!supply_ok) state_nxt = S_FAULT;
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OFF;
            deb_cnt   <= '0;
            set_cnt   <= '0;
            fault_src <= 3'b000;
            atb_ack   <= 1'b0;
            atb_err   <= 1'b0;
            atb_ena   <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                deb_cnt <= '0;
                set_cnt <= '0;
            end else begin
                // Both counters leave their state before reaching their last value + 1
                if (state == S_WAIT) deb_cnt <= supply_ok ? deb_cnt + 1'b1 : '0;
                if (state == S_PWR)  set_cnt <= set_cnt + 1'b1;
            end

            if (state_nxt == S_FAULT && state != S_FAULT)
                fault_src <= ~{ok_1p8, ok_0p8, ok_vss};
            else if (state_nxt != S_FAULT)
                fault_src <= 3'b000;

            atb_ack <= accept;
            atb_err <= accept && (state != S_READY);
            // Leaving READY wins over a testbus update accepted on the same edge
            if (state_nxt != S_READY)
                atb_ena <= 2'b00;
            else if (accept && state == S_READY)
                atb_ena <= atb_sel;
        end
    end

    assign pdb        = (state == S_PWR) || (state == S_READY);
    assign bias_ready = (state == S_READY);
    assign fault      = (state == S_FAULT);

endmodule

// File: tb/tb_local_bias_seq.sv
// tb/tb_local_bias_seq.sv - randomized self-checking bench for local_bias_seq
module tb_local_bias_seq;

    localparam int  DEB = 8;
    localparam int  SET = 64;
    localparam real R18 = 1.8;
    localparam real R08 = 0.8;
    localparam int  P_OFF = 0, P_WAIT = 1, P_PWR = 2, P_RDY = 3, P_FLT = 4;

    logic       clk;
    logic       rst;
    logic       en;
    real        v18, v08, vss;
    logic       atb_req;
    logic [1:0] atb_sel;
    logic       pdb;
    logic [1:0] atb_ena;
    logic       bias_ready;
    logic       fault;
    logic [2:0] fault_src;
    logic       atb_ack;
    logic       atb_err;

    int checks = 0;
    int errors = 0;

    int       m_ph, m_run, m_age;
    bit [2:0] m_src;
    bit       m_ack, m_err;
    bit [1:0] m_ena;

    local_bias_seq #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET),
        .VDDANA_1P8_REF (R18),
        .VDDANA_0P8_REF (R08)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .vddana_1p8(v18),
        .vddana_0p8(v08),
        .vssana    (vss),
        .atb_req   (atb_req),
        .atb_sel   (atb_sel),
        .pdb       (pdb),
        .atb_ena   (atb_ena),
        .bias_ready(bias_ready),
        .fault     (fault),
        .fault_src (fault_src),
        .atb_ack   (atb_ack),
        .atb_err   (atb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the sequencer should look like after one clock edge
    task automatic model_edge();
        bit ok18, ok08, okss, sok, acc;
        int prev;
        ok18 = (v18 >= 0.95 * R18) && (v18 <= 1.05 * R18);
        ok08 = (v08 >= 0.95 * R08) && (v08 <= 1.05 * R08);
        okss = (vss >= -0.05) && (vss <= 0.05);
        sok  = ok18 && ok08 && okss;
        prev = m_ph;
        acc  = atb_req && !m_ack;
        if (rst) begin
            m_ph = P_OFF; m_run = 0; m_age = 0; m_src = 0;
            m_ack = 0; m_err = 0; m_ena = 0;
            return;
        end
        m_ack = acc;
        m_err = acc && (prev != P_RDY);
        if (!en) begin
            m_ph = P_OFF;
            m_src = 0;
        end else begin
            case (prev)
                P_OFF: begin m_ph = P_WAIT; m_run = 0; end
                P_WAIT: begin
                    m_run = sok ? m_run + 1 : 0;
                    if (m_run == DEB) begin m_ph = P_PWR; m_age = 0; end
                end
                P_PWR: begin
                    if (!sok) begin
                        m_ph = P_FLT; m_src = {!ok18, !ok08, !okss};
                    end else begin
                        m_age++;
                        if (m_age == SET) m_ph = P_RDY;
                    end
                end
                P_RDY: if (!sok) begin m_ph = P_FLT; m_src = {!ok18, !ok08, !okss}; end
                default: ;
            endcase
        end
        if (m_ph != P_RDY) m_ena = 0;
        else if (acc && prev == P_RDY) m_ena = atb_sel;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pdb",        8'(pdb),        8'(m_ph == P_PWR || m_ph == P_RDY));
        chk("bias_ready", 8'(bias_ready), 8'(m_ph == P_RDY));
        chk("fault",      8'(fault),      8'(m_ph == P_FLT));
        chk("fault_src",  8'(fault_src),  8'(m_src));
        chk("atb_ack",    8'(atb_ack),    8'(m_ack));
        chk("atb_err",    8'(atb_err),    8'(m_err));
        chk("atb_ena",    8'(atb_ena),    8'(m_ena));
    endtask

    task automatic do_reset();
        rst = 1; en = 0; atb_req = 0; atb_sel = 0;
        v18 = R18; v08 = R08; vss = 0.0;
        step(); step();
        rst = 0;
    endtask

    function automatic real rail(input real nom, input int r);
        if (r < 9000) return nom;
        if (r < 9500) return nom * 0.95;
        if (r < 9990) return nom * 1.05;
        if (r < 9995) return nom * 0.9;
        return nom * 1.1;
    endfunction

    function automatic real gnd(input int r);
        if (r < 9000) return 0.0;
        if (r < 9500) return -0.05;
        if (r < 9990) return 0.05;
        if (r < 9995) return -0.1;
        return 0.12;
    endfunction

    initial begin
        int pdb_at, rdy_at;

        // Nominal power-up
        do_reset();
        chk("reset_pdb", 8'(pdb), 8'd0);
        en = 1; pdb_at = -1; rdy_at = -1;
        for (int c = 0; c < 80; c++) begin
            step();
            if (pdb && pdb_at < 0) pdb_at = c + 1;
            if (bias_ready && rdy_at < 0) rdy_at = c + 1;
        end
        chk("pdb_rise_cycle", 8'(pdb_at), 8'd9);
        chk("ready_cycle",    8'(rdy_at), 8'd73);

        // Debounce restart after a one-cycle 0p8 dip
        do_reset();
        en = 1; pdb_at = -1;
        for (int c = 0; c < 20; c++) begin
            v08 = (c == 5) ? 0.70 : R08;
            step();
            if (pdb && pdb_at < 0) pdb_at = c + 1;
        end
        chk("debounce_pdb_cycle", 8'(pdb_at), 8'd14);
        chk("debounce_no_fault",  8'(fault),  8'd0);

        // Rail fault in READY, held until en drops
        repeat (70) step();
        chk("ready_before_fault", 8'(bias_ready), 8'd1);
        v18 = 1.70; step();
        chk("fault_1p8_src", 8'(fault_src), 8'h4);
        chk("fault_1p8_pdb", 8'(pdb), 8'd0);
        v18 = R18; repeat (5) step();
        chk("fault_sticky", 8'(fault), 8'd1);
        en = 0; step();
        chk("fault_cleared", 8'(fault), 8'd0);

        // Testbus select in READY, then ground fault
        en = 1; repeat (80) step();
        atb_sel = 2'b11; atb_req = 1; step();
        atb_req = 0;
        chk("atb_ready_ack", 8'(atb_ack), 8'd1);
        chk("atb_ready_err", 8'(atb_err), 8'd0);
        chk("atb_ready_ena", 8'(atb_ena), 8'h3);
        vss = 0.1; step();
        chk("atb_fault_ena", 8'(atb_ena),   8'h0);
        chk("vss_fault_src", 8'(fault_src), 8'h1);
        vss = 0.0; en = 0; step();

        // Testbus select during POWER_UP, held request
        en = 1; repeat (12) step();
        atb_sel = 2'b10; atb_req = 1; step();
        chk("atb_pwr_ack", 8'(atb_ack), 8'd1);
        chk("atb_pwr_err", 8'(atb_err), 8'd1);
        chk("atb_pwr_ena", 8'(atb_ena), 8'h0);
        step();
        chk("atb_hold_gap", 8'(atb_ack), 8'd0);
        step();
        chk("atb_hold_reack", 8'(atb_ack), 8'd1);
        atb_req = 0;

        // Upper bound of the 0p8 window counts as good
        en = 0; step();
        en = 1; v08 = 0.84; repeat (80) step();
        chk("boundary_0p84_ready", 8'(bias_ready), 8'd1);
        v08 = R08;

        // Reset in the middle of POWER_UP
        en = 0; step(); en = 1;
        repeat (12) step();
        rst = 1; step(); rst = 0;
        chk("midrst_pdb", 8'(pdb), 8'd0);
        chk("midrst_ack", 8'(atb_ack), 8'd0);

        // Randomized run against the reference model
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(999) == 0);
            en      = ($urandom_range(999) >= 2);
            v18     = rail(R18, int'($urandom_range(9999)));
            v08     = rail(R08, int'($urandom_range(9999)));
            vss     = gnd(int'($urandom_range(9999)));
            atb_req = 1'($urandom_range(1));
            atb_sel = 2'($urandom_range(3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
